// File: rtl/glb_2_lb.sv
// glb_2_lb: copies a length x height tile from the global buffer (GLB) into
// the local buffer (LB). The tile is read row by row from the GLB, with a
// row pitch of big_length words. Each word is written to the next sequential
// LB address one cycle after it is read.
//
// Ports:
//   clock, rst_n        rising-edge clock; asynchronous active-low reset
//   trans_start         level request, sampled only in IDLE
//   trans_end           one-cycle completion pulse
//   base_addr           GLB address of tile element (0,0)
//   big_length          GLB row pitch in words
//   length, height      tile row length and row count in words
//   rd_en, rd_addr      GLB read strobe and address (address held while idle)
//   data_in             GLB read data, valid the cycle after rd_en
//   wr_en, wr_addr      LB write strobe and address (address held while idle)
//   data_out            LB write data (held while idle)
//
// Build option:
//   GLB_2_LB_OUTREG_EN  adds an extra register stage on wr_en, wr_addr and
//                       data_out. FLUSH then lasts two cycles so that the
//                       final write drains before trans_end.
module glb_2_lb #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned GLB_AW = 15,
  parameter int unsigned LB_AW  = 10
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              trans_start,
  output logic              trans_end,
  input  logic [GLB_AW-1:0] base_addr,
  input  logic [7:0]        big_length,
  input  logic [5:0]        length,
  input  logic [5:0]        height,
  output logic              rd_en,
  output logic [GLB_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_en,
  output logic [LB_AW-1:0]  wr_addr,
  output logic [DATA_W-1:0] data_out
);

  typedef enum logic [1:0] {StIdle, StRead, StFlush, StDone} state_e;

  state_e state_q, state_d;

  // Transfer parameters, latched on start
  logic [7:0]        pitch_q;
  logic [5:0]        len_q;
  logic [5:0]        hgt_q;

  // Read-side walk
  logic [5:0]        col_q;
  logic [5:0]        row_q;
  logic [GLB_AW-1:0] row_base_q;   // GLB address of element (row_q, 0)
  logic [GLB_AW-1:0] cur_addr_q;   // address presented while reading
  logic [GLB_AW-1:0] rd_hold_q;    // last address actually read
  logic [LB_AW-1:0]  k_q;          // linear element index, wraps silently

  // Write stage (one cycle behind the read)
  logic              wr_en_s1_q;
  logic [LB_AW-1:0]  wr_addr_s1_q;

  logic              start;
  logic              zero_tile;
  logic              last_elem;
  logic [GLB_AW-1:0] pitch_ext;
  logic [GLB_AW-1:0] next_row_base;

  assign start         = (state_q == StIdle) && trans_start;
  assign zero_tile     = (length == 6'd0) || (height == 6'd0);
  assign last_elem     = (col_q == len_q - 6'd1) && (row_q == hgt_q - 6'd1);
  assign pitch_ext     = GLB_AW'(pitch_q);
  assign next_row_base = row_base_q + pitch_ext;

  assign rd_en     = (state_q == StRead);
  assign trans_end = (state_q == StDone);
  // The live address appears only while reading. Otherwise the last read
  // address is shown, so that loading a new base never disturbs an idle bus.
  assign rd_addr   = rd_en ? cur_addr_q : rd_hold_q;

`ifdef GLB_2_LB_OUTREG_EN
  logic              flush_q;
  logic              wr_en_q;
  logic [LB_AW-1:0]  wr_addr_q;
  logic [DATA_W-1:0] data_out_q;
`else
  logic [DATA_W-1:0] data_hold_q;
`endif

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (trans_start) begin
          state_d = zero_tile ? StDone : StRead;
        end
      end
      StRead: begin
        if (last_elem) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
`ifdef GLB_2_LB_OUTREG_EN
        if (flush_q) begin
          state_d = StDone;
        end
`else
        state_d = StDone;
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Address generation and the first write stage
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pitch_q      <= '0;
      len_q        <= '0;
      hgt_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      cur_addr_q   <= '0;
      rd_hold_q    <= '0;
      k_q          <= '0;
      wr_en_s1_q   <= 1'b0;
      wr_addr_s1_q <= '0;
    end else begin
      if (start) begin
        pitch_q    <= big_length;
        len_q      <= length;
        hgt_q      <= height;
        col_q      <= '0;
        row_q      <= '0;
        row_base_q <= base_addr;
        cur_addr_q <= base_addr;
        k_q        <= '0;
      end else if (rd_en) begin
        rd_hold_q <= cur_addr_q;
        k_q       <= k_q + 1'b1;
        if (col_q == len_q - 6'd1) begin
          // Jump straight to the next row so that no bubble appears at the boundary
          col_q      <= '0;
          row_q      <= row_q + 6'd1;
          row_base_q <= next_row_base;
          cur_addr_q <= next_row_base;
        end else begin
          col_q      <= col_q + 6'd1;
          cur_addr_q <= cur_addr_q + 1'b1;
        end
      end
      wr_en_s1_q <= rd_en;
      if (rd_en) begin
        wr_addr_s1_q <= k_q;
      end
    end
  end

`ifdef GLB_2_LB_OUTREG_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      flush_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      data_out_q <= '0;
    end else begin
      flush_q <= (state_q == StFlush) && !flush_q;
      wr_en_q <= wr_en_s1_q;
      if (wr_en_s1_q) begin
        wr_addr_q  <= wr_addr_s1_q;
        data_out_q <= data_in;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign data_out = data_out_q;
`else
  // The data word arrives during the write cycle itself. It passes straight
  // through and is captured so that it stays on the bus after wr_en drops.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      data_hold_q <= '0;
    end else if (wr_en_s1_q) begin
      data_hold_q <= data_in;
    end
  end

  assign wr_en    = wr_en_s1_q;
  assign wr_addr  = wr_addr_s1_q;
  assign data_out = wr_en_s1_q ? data_in : data_hold_q;
`endif

endmodule

// File: tb/tb_glb_2_lb.sv
// Directed testbench for glb_2_lb in its default build. The GLB is modelled
// so that data_in returns the address that was presented in the previous cycle.
module tb_glb_2_lb;
  localparam int DW = 128;
  localparam int GA = 15;
  localparam int LA = 10;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          trans_start = 1'b0;
  logic          trans_end;
  logic [GA-1:0] base_addr = '0;
  logic [7:0]    big_length = '0;
  logic [5:0]    length = '0;
  logic [5:0]    height = '0;
  logic          rd_en;
  logic [GA-1:0] rd_addr;
  logic [DW-1:0] data_in = '0;
  logic          wr_en;
  logic [LA-1:0] wr_addr;
  logic [DW-1:0] data_out;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  always @(posedge clock) data_in <= DW'(rd_addr);

  glb_2_lb #(.DATA_W(DW), .GLB_AW(GA), .LB_AW(LA)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .trans_start (trans_start),
    .trans_end   (trans_end),
    .base_addr   (base_addr),
    .big_length  (big_length),
    .length      (length),
    .height      (height),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .data_out    (data_out)
  );

  // Present a request for one cycle. Returns at the negedge of cycle T.
  task automatic start_xfer(input logic [GA-1:0] b, input logic [7:0] bl,
                            input logic [5:0] l, input logic [5:0] h);
    @(negedge clock);
    base_addr   = b;
    big_length  = bl;
    length      = l;
    height      = h;
    trans_start = 1'b1;
    @(negedge clock);
    trans_start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL reset rd_en got %b want 0", rd_en); end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset wr_en got %b want 0", wr_en); end
    tests++; if (trans_end !== 1'b0) begin fails++; $display("FAIL reset trans_end got %b want 0", trans_end); end
    tests++; if (rd_addr !== '0) begin fails++; $display("FAIL reset rd_addr got %h want 0", rd_addr); end
    tests++; if (wr_addr !== '0) begin fails++; $display("FAIL reset wr_addr got %h want 0", wr_addr); end
    tests++; if (data_out !== '0) begin fails++; $display("FAIL reset data_out got %h want 0", data_out); end
    @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // 3x3 tile with a pitch of 3 (dense), so addresses 0..8
  task automatic test_basic;
    logic [GA-1:0] ea [9];
    int ei, wi;
    for (int i = 0; i < 9; i++) ea[i] = GA'(i);
    start_xfer('0, 8'd3, 6'd3, 6'd3);
    for (int c = 0; c <= 10; c++) begin
      ei = (c < 9) ? c : 8;
      wi = (c - 1 < 9) ? c - 1 : 8;
      tests++; if (rd_en !== (c < 9)) begin fails++; $display("FAIL basic rd_en c=%0d got %b want %b", c, rd_en, (c < 9)); end
      tests++; if (rd_addr !== ea[ei]) begin fails++; $display("FAIL basic rd_addr c=%0d got %h want %h", c, rd_addr, ea[ei]); end
      if (c >= 1) begin
        tests++; if (wr_en !== (c <= 9)) begin fails++; $display("FAIL basic wr_en c=%0d got %b want %b", c, wr_en, (c <= 9)); end
        tests++; if (wr_addr !== LA'(wi)) begin fails++; $display("FAIL basic wr_addr c=%0d got %0d want %0d", c, wr_addr, wi); end
        tests++; if (data_out !== DW'(ea[wi])) begin fails++; $display("FAIL basic data_out c=%0d got %h want %h", c, data_out, ea[wi]); end
      end
      tests++; if (trans_end !== (c == 10)) begin fails++; $display("FAIL basic trans_end c=%0d got %b want %b", c, trans_end, (c == 10)); end
      @(negedge clock);
    end
  endtask

  // 4x2 tile at base 100 with a pitch of 16. The inputs are scrambled after the latch.
  task automatic test_pitch;
    logic [GA-1:0] ea [8];
    int ei, wi;
    ea[0] = 100; ea[1] = 101; ea[2] = 102; ea[3] = 103;
    ea[4] = 116; ea[5] = 117; ea[6] = 118; ea[7] = 119;
    start_xfer(GA'(100), 8'd16, 6'd4, 6'd2);
    base_addr = GA'(555); big_length = 8'd1; length = 6'd9; height = 6'd9;
    for (int c = 0; c <= 9; c++) begin
      ei = (c < 8) ? c : 7;
      wi = (c - 1 < 8) ? c - 1 : 7;
      tests++; if (rd_en !== (c < 8)) begin fails++; $display("FAIL pitch rd_en c=%0d got %b want %b", c, rd_en, (c < 8)); end
      tests++; if (rd_addr !== ea[ei]) begin fails++; $display("FAIL pitch rd_addr c=%0d got %0d want %0d", c, rd_addr, ea[ei]); end
      if (c >= 1) begin
        tests++; if (wr_en !== (c <= 8)) begin fails++; $display("FAIL pitch wr_en c=%0d got %b want %b", c, wr_en, (c <= 8)); end
        tests++; if (wr_addr !== LA'(wi)) begin fails++; $display("FAIL pitch wr_addr c=%0d got %0d want %0d", c, wr_addr, wi); end
        tests++; if (data_out !== DW'(ea[wi])) begin fails++; $display("FAIL pitch data_out c=%0d got %0d want %0d", c, data_out, ea[wi]); end
      end
      tests++; if (trans_end !== (c == 9)) begin fails++; $display("FAIL pitch trans_end c=%0d got %b want %b", c, trans_end, (c == 9)); end
      @(negedge clock);
    end
    base_addr = '0; big_length = '0; length = '0; height = '0;
  endtask

  // Row start past the top of the GLB wraps modulo 2^15
  task automatic test_wrap;
    logic [GA-1:0] ea [4];
    int ei;
    ea[0] = 15'h7FFE; ea[1] = 15'h7FFF; ea[2] = 15'h0000; ea[3] = 15'h0001;
    start_xfer(15'h7FFE, 8'd2, 6'd2, 6'd2);
    for (int c = 0; c <= 5; c++) begin
      ei = (c < 4) ? c : 3;
      tests++; if (rd_addr !== ea[ei]) begin fails++; $display("FAIL wrap rd_addr c=%0d got %h want %h", c, rd_addr, ea[ei]); end
      tests++; if (trans_end !== (c == 5)) begin fails++; $display("FAIL wrap trans_end c=%0d got %b want %b", c, trans_end, (c == 5)); end
      @(negedge clock);
    end
  endtask

  task automatic test_zero;
    start_xfer(GA'(5), 8'd4, 6'd0, 6'd5);
    tests++; if (trans_end !== 1'b1) begin fails++; $display("FAIL zero trans_end at T got %b want 1", trans_end); end
    tests++; if (rd_en !== 1'b0) begin fails++; $display("FAIL zero rd_en at T got %b want 0", rd_en); end
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL zero wr_en at T got %b want 0", wr_en); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      tests++; if (trans_end !== 1'b0) begin fails++; $display("FAIL zero trans_end c=%0d got %b want 0", c, trans_end); end
      tests++; if (rd_en !== 1'b0 || wr_en !== 1'b0) begin fails++; $display("FAIL zero strobes c=%0d got rd=%b wr=%b want 0", c, rd_en, wr_en); end
    end
  endtask

  task automatic test_reset_mid;
    start_xfer('0, 8'd3, 6'd3, 6'd3);
    repeat (3) @(negedge clock);
    tests++; if (rd_en !== 1'b1) begin fails++; $display("FAIL abort rd_en before reset got %b want 1", rd_en); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (rd_en !== 1'b0 || wr_en !== 1'b0 || trans_end !== 1'b0) begin fails++; $display("FAIL abort strobes got rd=%b wr=%b te=%b want 0", rd_en, wr_en, trans_end); end
    tests++; if (rd_addr !== '0 || wr_addr !== '0) begin fails++; $display("FAIL abort addrs got rd=%h wr=%h want 0", rd_addr, wr_addr); end
    tests++; if (data_out !== '0) begin fails++; $display("FAIL abort data_out got %h want 0", data_out); end
    @(negedge clock);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      tests++; if (trans_end !== 1'b0 || rd_en !== 1'b0) begin fails++; $display("FAIL abort resumed c=%0d got te=%b rd=%b want 0", c, trans_end, rd_en); end
    end
    start_xfer(GA'(50), 8'd8, 6'd2, 6'd1);
    tests++; if (rd_addr !== GA'(50)) begin fails++; $display("FAIL abort_new rd_addr got %0d want 50", rd_addr); end
    @(negedge clock);
    tests++; if (wr_en !== 1'b1 || wr_addr !== LA'(0)) begin fails++; $display("FAIL abort_new first write got en=%b addr=%0d want 1/0", wr_en, wr_addr); end
    tests++; if (data_out !== DW'(50)) begin fails++; $display("FAIL abort_new data_out got %0d want 50", data_out); end
    @(negedge clock);
    tests++; if (wr_addr !== LA'(1) || data_out !== DW'(51)) begin fails++; $display("FAIL abort_new second write got addr=%0d data=%0d want 1/51", wr_addr, data_out); end
    @(negedge clock);
    tests++; if (trans_end !== 1'b1) begin fails++; $display("FAIL abort_new trans_end got %b want 1", trans_end); end
    repeat (2) @(negedge clock);
  endtask

  // trans_start held high with N=2: pulses at T+3 and T+8
  task automatic test_back_to_back;
    int te1, te2;
    te1 = -1; te2 = -1;
    @(negedge clock);
    base_addr = GA'(10); big_length = 8'd4; length = 6'd2; height = 6'd1;
    trans_start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (i == 5) begin
        tests++; if (rd_en !== 1'b1 || rd_addr !== GA'(10)) begin fails++; $display("FAIL b2b restart got rd=%b addr=%0d want 1/10", rd_en, rd_addr); end
      end
      if (trans_end === 1'b1) begin
        if (te1 < 0) te1 = i;
        else if (te2 < 0) te2 = i;
      end
    end
    trans_start = 1'b0;
    tests++; if (te1 !== 3) begin fails++; $display("FAIL b2b first trans_end got %0d want 3", te1); end
    tests++; if (te2 !== 8) begin fails++; $display("FAIL b2b second trans_end got %0d want 8", te2); end
    repeat (8) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pitch();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
